// File: rtl/spm_pkg.sv
// spm_pkg: definitions shared by the spm_seq sequencer, its bus interface
// and the spm serial-parallel multiplier.
//   SPM_SIZE     default operand width in bits
//   state_e      sequencer states IDLE / CLR / SHIFT / DONE
//   count_width  width of the serial bit counter, which must hold 0..2*size
package spm_pkg;

    localparam int SPM_SIZE = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int count_width(input int size);
        return $clog2(2 * size + 1);
    endfunction

    localparam int SPM_CW = count_width(SPM_SIZE);

endpackage

// File: rtl/spm_seq_if.sv
// spm_seq_if: operand/product handshake bundle of the spm_seq sequencer.
//   in_valid / in_ready    operand pair handshake (mc, mp signed SIZE bits)
//   out_valid / out_ready  product handshake (prod signed 2*SIZE bits)
// master = producer of operands and consumer of products; slave = spm_seq.
interface spm_seq_if
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE
);
    logic                in_valid;
    logic                in_ready;
    logic [SIZE-1:0]     mc;
    logic [SIZE-1:0]     mp;
    logic                out_valid;
    logic                out_ready;
    logic [2*SIZE-1:0]   prod;

    modport master (
        output in_valid, mc, mp, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, mc, mp, out_ready,
        output in_ready, out_valid, prod
    );
endinterface

// File: rtl/spm_seq_spm.sv
// spm: signed serial-parallel multiplier.
//   clk_i  clock
//   rst_i  synchronous active-high clear of the whole carry-save chain
//   x_i    SIZE-bit signed multiplicand, held parallel for the whole operation
//   y_i    multiplier bits, LSB first, sign-extended to 2*SIZE bits
//   p_o    product bits, LSB first, one cycle behind the y bit that completes them
// Stages 0..SIZE-2 are carry-save adders for the positive-weight bits of x;
// the top stage is a serial two's-complement negator for the sign bit of x,
// whose weight is -2^(SIZE-1). Each stage's sum ripples one stage down per
// cycle, which lines stage i up with weight 2^i at the output.
module spm
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SIZE-1:0] x_i,
    input  logic            y_i,
    output logic            p_o
);

    logic [SIZE-2:0] sum_q;
    logic [SIZE-2:0] sum_d;
    logic [SIZE-2:0] carry_q;
    logic [SIZE-2:0] carry_d;
    logic            neg_s_q;
    logic            neg_s_d;
    logic            neg_z_q;
    logic            neg_z_d;

    logic [SIZE-1:0] xy_s;
    logic [SIZE-1:0] chain_s;

    assign xy_s    = x_i & {SIZE{y_i}};
    // chain_s[i] is the partial sum entering stage i-1; chain_s[0] is the output.
    assign chain_s = {neg_s_q, sum_q};
    assign p_o     = chain_s[0];

    // Next state of the carry-save stages and of the sign-bit negator.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        for (int i = 0; i < SIZE - 1; i++) begin
            sum_d[i]   = xy_s[i] ^ chain_s[i+1] ^ carry_q[i];
            carry_d[i] = (xy_s[i] & chain_s[i+1]) |
                         (xy_s[i] & carry_q[i])   |
                         (chain_s[i+1] & carry_q[i]);
        end
        // Serial negate, LSB first: pass bits through until the first 1,
        // invert everything after it.
        neg_s_d = xy_s[SIZE-1] ^ neg_z_q;
        neg_z_d = xy_s[SIZE-1] | neg_z_q;
    end

    // Chain registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q   <= {(SIZE-1){1'b0}};
            carry_q <= {(SIZE-1){1'b0}};
            neg_s_q <= 1'b0;
            neg_z_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            neg_s_q <= neg_s_d;
            neg_z_q <= neg_z_d;
        end
    end

endmodule

// File: rtl/spm_seq.sv
// spm_seq: parallel front/back end for the spm serial-parallel multiplier.
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   spm_seq_if slave: accepts (mc, mp) on in_valid/in_ready and returns
//         the exact signed 2*SIZE-bit product on out_valid/out_ready
// Per operation: IDLE accepts and latches the operands, CLR clears the spm
// chain for one cycle, SHIFT runs 2*SIZE+1 cycles feeding the sign-extended
// multiplier LSB first and collecting the serial product, DONE holds the
// result until the consumer takes it.
module spm_seq
    import spm_pkg::*;
#(
    parameter int SIZE = SPM_SIZE
) (
    input  logic      clk,
    input  logic      rst,
    spm_seq_if.slave  bus
);

    localparam int CW = count_width(SIZE);
    localparam int PW = 2 * SIZE;

    localparam logic [1:0] IDLE  = S_IDLE;
    localparam logic [1:0] CLR   = S_CLR;
    localparam logic [1:0] SHIFT = S_SHIFT;
    localparam logic [1:0] DONE  = S_DONE;

    localparam logic [CW-1:0] LAST_CNT = CW'(PW);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [SIZE-1:0] x_q;
    logic [SIZE-1:0] x_d;
    logic [SIZE-1:0] y_q;
    logic [SIZE-1:0] y_d;
    logic [PW-1:0]   prod_q;
    logic [PW-1:0]   prod_d;
    logic            in_ready_q;
    logic            in_ready_d;
    logic            out_valid_q;
    logic            out_valid_d;

    logic            spm_rst_s;
    logic            spm_y_s;
    logic            spm_p_s;

    // The chain is cleared by the block reset and by the CLR cycle of every op.
    assign spm_rst_s = rst | (state_q == CLR);

    spm #(
        .SIZE (SIZE)
    ) u_spm (
        .clk_i (clk),
        .rst_i (spm_rst_s),
        .x_i   (x_q),
        .y_i   (spm_y_s),
        .p_o   (spm_p_s)
    );

    // Sequencer next-state and datapath next-state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        prod_d  = prod_q;
        spm_y_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.mc;
                    y_d     = bus.mp;
                    prod_d  = {PW{1'b0}};
                    state_d = CLR;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR: begin
                count_d = {CW{1'b0}};
                state_d = SHIFT;
            end
            SHIFT: begin
                // After SIZE shifts the arithmetic shift has filled y_q with
                // copies of the sign bit, giving the sign extension for free.
                if (count_q != LAST_CNT) begin
                    spm_y_s = y_q[0];
                end else begin
                    spm_y_s = 1'b0;
                end
                y_d    = {y_q[SIZE-1], y_q[SIZE-1:1]};
                // The first bit captured is the cleared-chain zero; it falls
                // off the bottom by the last shift.
                prod_d = {spm_p_s, prod_q[PW-1:1]};
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and handshake flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= {CW{1'b0}};
            x_q         <= {SIZE{1'b0}};
            y_q         <= {SIZE{1'b0}};
            prod_q      <= {PW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            y_q         <= y_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.prod      = prod_q;

endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: directed and randomized self-checking bench for spm_seq.
module tb_spm_seq;
    import spm_pkg::*;

    localparam int SIZE = 32;
    localparam int W    = 2 * SIZE;
    localparam int LAT  = 2 * SIZE + 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    spm_seq_if #(.SIZE(SIZE)) bus ();

    spm_seq #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic logic [W-1:0] ref_prod(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return W'(sa * sb);
    endfunction

    function automatic logic [SIZE-1:0] rand_operand();
        case ($urandom_range(7, 0))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(15, 0));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operand pair, waits for out_valid, checks latency, product
    // and that in_ready stayed low. Returns with the DUT in DONE.
    task automatic run_op(input string tag, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] b, input logic [W-1:0] exp);
        int cyc;
        bit rdy_seen;
        check({tag, " in_ready_idle"}, W'(bus.in_ready), W'(1'b1));
        bus.mc       = a;
        bus.mp       = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mc       = 32'($urandom);
        bus.mp       = 32'($urandom);
        cyc          = 1;
        rdy_seen     = 1'b0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            step();
            cyc++;
        end
        check({tag, " latency"}, W'(cyc), W'(LAT));
        check({tag, " prod"}, bus.prod, exp);
        check({tag, " model"}, bus.prod, ref_prod(a, b));
        check({tag, " in_ready_busy"}, W'(rdy_seen), W'(1'b0));
    endtask

    task automatic release_check(input string tag);
        step();
        check({tag, " out_valid_after"}, W'(bus.out_valid), W'(1'b0));
        check({tag, " in_ready_after"}, W'(bus.in_ready), W'(1'b1));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] q[$];
        int sent;
        int got;
        int guard;
        int both_high;

        bus.in_valid  = 1'b0;
        bus.mc        = 32'd0;
        bus.mp        = 32'd0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        step();
        check("reset in_ready", W'(bus.in_ready), W'(1'b1));
        check("reset out_valid", W'(bus.out_valid), W'(1'b0));
        check("reset prod", bus.prod, 64'd0);
        rst = 1'b0;
        step();

        // Directed products with out_ready held high.
        run_op("3x5", 32'd3, 32'd5, 64'd15);
        release_check("3x5");
        run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        release_check("m1xm1");
        run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        release_check("m7x6");
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        release_check("minxmin");
        run_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        release_check("maxxmin");

        // Back-pressure: result must hold and in_valid must be ignored.
        bus.out_ready = 1'b0;
        run_op("stall", 32'd11, 32'hFFFF_FFF3, 64'hFFFF_FFFF_FFFF_FF71);
        held = bus.prod;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
            bus.mc       = 32'($urandom);
            bus.mp       = 32'($urandom);
            step();
            check("stall out_valid", W'(bus.out_valid), W'(1'b1));
            check("stall prod", bus.prod, held);
            check("stall in_ready", W'(bus.in_ready), W'(1'b0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        release_check("stall");

        // Reset in SHIFT at count=20, then a clean op must be unaffected.
        bus.mc       = 32'd123;
        bus.mp       = 32'hFFFF_FFB3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (21) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", W'(bus.out_valid), W'(1'b0));
        check("midrst in_ready", W'(bus.in_ready), W'(1'b1));
        check("midrst prod", bus.prod, 64'd0);
        run_op("after_rst 3x5", 32'd3, 32'd5, 64'd15);
        release_check("after_rst");

        // Random stream: in_valid held high, random out_ready.
        sent      = 0;
        got       = 0;
        guard     = 0;
        both_high = 0;
        bus.in_valid = 1'b1;
        while (got < 100 && guard < 20000) begin
            bus.out_ready = 1'($urandom_range(1, 0));
            if (bus.in_ready && bus.out_valid) both_high++;
            bus.mc = rand_operand();
            bus.mp = rand_operand();
            if (bus.in_ready) begin
                if (sent < 100) begin
                    bus.in_valid = 1'b1;
                    q.push_back(ref_prod(bus.mc, bus.mp));
                    sent++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                check("rand result_expected", W'(q.size() > 0), W'(1'b1));
                if (q.size() > 0) check("rand prod", bus.prod, q.pop_front());
                got++;
            end
            step();
            guard++;
        end
        bus.in_valid = 1'b0;
        check("rand results", W'(got), W'(100));
        check("rand accepts", W'(sent), W'(100));
        check("rand leftover", W'(q.size()), W'(0));
        check("rand ready_valid_overlap", W'(both_high), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
